// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore control FSM for a multicycle MIPS datapath (PC, IR, register file,
//   ALU, one shared instruction/data memory). Each state drives the datapath
//   mux selects and write strobes. The FSM stalls on the memory handshake,
//   traps on illegal opcodes and memory timeouts, and counts retired
//   instructions.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   opcode[5:0]           IR[31:26], valid from DECODE onward
//   mem_ready             memory completed the current access this cycle
//   pc_write, pc_write_cond, pc_source[1:0]   PC update controls
//   i_or_d, mem_read, mem_write, ir_write     memory / IR controls
//   reg_dst, mem_to_reg, reg_write            register file controls
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]    ALU controls
//   state[3:0]            current state encoding (debug)
//   fault[1:0]            00 none, 01 illegal opcode, 10 memory timeout (sticky)
//   inst_count[CNT_W-1:0] retired instructions, wraps
//
// Memory handshake: in FETCH, MEMRD and MEMWR the request (mem_read or
// mem_write) stays asserted with the same address select until a cycle in
// which mem_ready=1. That cycle completes the access, and the FSM leaves the
// state on the following edge. A request is never withdrawn before
// mem_ready, except by a timeout trap or by reset.
module mips_multicycle_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // The counter only has to reach MAX_WAIT-1. With the timeout disabled it
  // simply wraps, which is harmless.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            cur;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;

  // A cycle with mem_ready=1 always completes normally, even at the limit.
  assign timeout = (MAX_WAIT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);
  assign state   = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= S_FETCH;
      wait_cnt   <= '0;
      fault      <= 2'b00;
      inst_count <= '0;
    end else begin
      // Any state change clears the wait counter. Only the stall branches
      // below advance it.
      wait_cnt <= '0;
      case (cur)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            case (cur)
              S_FETCH: cur <= S_DECODE;
              S_MEMRD: cur <= S_MEMWB;
              default: begin
                cur        <= S_FETCH;
                inst_count <= inst_count + CNT_W'(1);
              end
            endcase
          end else if (timeout) begin
            cur   <= S_TRAP;
            fault <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_R:         cur <= S_EXEC;
            OP_BEQ:       cur <= S_BRANCH;
            OP_J:         cur <= S_JUMP;
            OP_ADDI:      cur <= S_ADDI_EX;
            default: begin
              cur   <= S_TRAP;
              fault <= 2'b01;
            end
          endcase
        end
        S_MEMADR:  cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_EXEC:    cur <= S_ALUWB;
        S_ADDI_EX: cur <= S_ADDI_WB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
          cur        <= S_FETCH;
          inst_count <= inst_count + CNT_W'(1);
        end
        S_TRAP:    cur <= S_TRAP;
        default:   cur <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state register. The one exception is FETCH,
  // where the IR and PC loads follow mem_ready. Reset masks every strobe and
  // request without waiting for a clock edge.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed test of mips_multicycle_ctrl (MAX_WAIT=4). Expected state
//   sequences are queued in exp_q and popped one per clock. Strobe, fault and
//   counter expectations are hand-computed constants.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  pc_source, alu_src_b, alu_op, fault;
  logic [3:0]  state;
  logic [31:0] inst_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  mips_multicycle_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .fault(fault), .inst_count(inst_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 2 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Tick once and compare the state against the head of the expected queue.
  task automatic step_state(input string tag);
    logic [3:0] e;
    tick();
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(state), 32'(e));
    end
  endtask

  task automatic push3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  initial begin
    // reset
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h23;
    #1 reset  = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", inst_count, 32'd0);
    check("rst_strobes", 32'({mem_read, ir_write, pc_write, reg_write}), 32'd0);

    // lw with mem_ready=1: 0,1,2,3,4,0
    reset = 1'b1;
    settle();
    check("fetch_strobes", 32'({mem_read, ir_write, pc_write}), 32'b111);
    check("fetch_srcb", 32'(alu_src_b), 32'd1);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    exp_q.push_back(4'd4); exp_q.push_back(4'd0);
    step_state("lw_s1");
    check("decode_srcb", 32'(alu_src_b), 32'd3);
    step_state("lw_s2");
    check("memadr_sel", 32'({alu_src_a, alu_src_b, reg_write}), 32'b1_10_0);
    step_state("lw_s3");
    check("memrd_sel", 32'({mem_read, i_or_d, reg_write}), 32'b110);
    step_state("lw_s4");
    check("memwb_sel", 32'({reg_write, mem_to_reg, reg_dst}), 32'b110);
    step_state("lw_s0");
    check("lw_rw_off", 32'(reg_write), 32'd0);
    check("lw_count", inst_count, 32'd1);

    // R-type: 0,1,6,7,0
    opcode = 6'h00;
    exp_q.push_back(4'd1); push3(4'd6, 4'd7, 4'd0);
    step_state("r_s1");
    step_state("r_s6");
    check("exec_sel", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_00_10);
    step_state("r_s7");
    check("aluwb_sel", 32'({reg_write, reg_dst}), 32'b11);
    step_state("r_s0");
    check("r_count", inst_count, 32'd2);

    // beq: 0,1,8,0
    opcode = 6'h04;
    push3(4'd1, 4'd8, 4'd0);
    step_state("beq_s1");
    step_state("beq_s8");
    check("branch_sel", 32'({pc_write_cond, pc_write, pc_source, alu_op, alu_src_a}), 32'b1_0_01_01_1);
    step_state("beq_s0");
    check("beq_count", inst_count, 32'd3);

    // j: 0,1,9,0
    opcode = 6'h02;
    push3(4'd1, 4'd9, 4'd0);
    step_state("j_s1");
    step_state("j_s9");
    check("jump_sel", 32'({pc_write, pc_source, pc_write_cond}), 32'b1_10_0);
    step_state("j_s0");
    check("j_count", inst_count, 32'd4);

    // addi: 0,1,10,11,0
    opcode = 6'h08;
    exp_q.push_back(4'd1); push3(4'd10, 4'd11, 4'd0);
    step_state("addi_s1");
    step_state("addi_s10");
    check("addi_ex_sel", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_10_00);
    step_state("addi_s11");
    check("addi_wb_sel", 32'({reg_write, reg_dst, mem_to_reg}), 32'b100);
    step_state("addi_s0");
    check("addi_count", inst_count, 32'd5);

    // sw with three not-ready cycles in MEMWR (the third reaches MAX_WAIT-1)
    opcode = 6'h2B;
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    step_state("sw_s1");
    step_state("sw_s2");
    mem_ready = 1'b0;
    push3(4'd5, 4'd5, 4'd5);
    for (int i = 0; i < 3; i++) begin
      step_state("sw_s5_wait");
      check("sw_mem_write", 32'({mem_write, i_or_d}), 32'b11);
    end
    step_state("sw_s5_last");
    mem_ready = 1'b1;
    settle();
    check("sw_last_cycle", 32'({state, mem_write}), 32'b0101_1);
    check("sw_count_hold", inst_count, 32'd5);
    exp_q.push_back(4'd0);
    step_state("sw_s0");
    check("sw_count", inst_count, 32'd6);
    check("sw_mw_off", 32'(mem_write), 32'd0);

    // async reset in the middle of MEMRD
    opcode = 6'h23;
    exp_q.push_back(4'd1); push3(4'd2, 4'd3, 4'd3);
    step_state("rd_s1");
    step_state("rd_s2");
    mem_ready = 1'b0;
    step_state("rd_s3");
    check("rd_req", 32'(mem_read), 32'd1);
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_strobes", 32'({mem_read, mem_write, ir_write, pc_write, reg_write}), 32'd0);
    tick();
    tick();
    mem_ready = 1'b1;
    reset = 1'b1;
    settle();
    check("rel_fault", 32'(fault), 32'd0);
    check("rel_count", inst_count, 32'd0);
    check("rel_state", 32'(state), 32'd0);

    // illegal opcode traps with fault=01
    opcode = 6'h3F;
    push3(4'd1, 4'd12, 4'd12);
    step_state("ill_s1");
    step_state("ill_trap");
    check("ill_fault", 32'(fault), 32'd1);
    check("ill_count", inst_count, 32'd0);
    check("ill_strobes", 32'({mem_read, mem_write, ir_write, pc_write, reg_write, pc_write_cond}), 32'd0);
    step_state("ill_hold");

    // FETCH timeout: four not-ready cycles then TRAP with fault=10
    reset = 1'b0;
    settle();
    check("rst2_fault", 32'(fault), 32'd0);
    tick();
    mem_ready = 1'b0;
    opcode = 6'h23;
    reset = 1'b1;
    settle();
    check("to_fetch", 32'({state, mem_read, ir_write, pc_write}), 32'b0000_100);
    exp_q.push_back(4'd0); push3(4'd0, 4'd0, 4'd12);
    step_state("to_w1");
    step_state("to_w2");
    step_state("to_w3");
    step_state("to_trap");
    check("to_fault", 32'(fault), 32'd2);
    check("to_strobes", 32'({mem_read, mem_write, ir_write, pc_write, reg_write}), 32'd0);
    mem_ready = 1'b1;
    exp_q.push_back(4'd12); exp_q.push_back(4'd12);
    step_state("to_hold1");
    step_state("to_hold2");
    check("to_hold_fault", 32'({fault, ir_write, pc_write}), 32'b10_00);
    check("to_count", inst_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
